// File: rtl/fft_mc_frame_arb.sv
// rtl/fft_mc_frame_arb.sv - multi-channel frame arbiter, config issuer and output tagger for the burst FFT core
module fft_mc_frame_arb #(
    parameter int NUM_CH     = 4,
    parameter int CH_WIDTH   = 2,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 9,
    parameter int TAG_DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_wr_en,
    input  logic [CH_WIDTH-1:0]        cfg_wr_ch,
    input  logic [23:0]                cfg_wr_data,
    input  logic [NUM_CH-1:0]          in_valid,
    input  logic [NUM_CH-1:0]          in_last,
    input  logic [NUM_CH*2*DATA_WIDTH-1:0] in_data,
    output logic [NUM_CH-1:0]          in_ready,
    output logic                       core_cfg_valid,
    output logic [23:0]                core_cfg_data,
    input  logic                       core_cfg_ready,
    output logic                       core_s_valid,
    output logic                       core_s_last,
    output logic [2*DATA_WIDTH-1:0]    core_s_data,
    input  logic                       core_s_ready,
    input  logic                       core_m_valid,
    input  logic                       core_m_last,
    input  logic [2*DATA_WIDTH-1:0]    core_m_data,
    input  logic [ADDR_WIDTH:0]        core_m_user,
    output logic                       core_m_ready,
    output logic                       o_valid,
    output logic                       o_last,
    output logic [2*DATA_WIDTH-1:0]    o_data,
    output logic [ADDR_WIDTH:0]        o_user,
    output logic [CH_WIDTH-1:0]        o_ch,
    input  logic                       o_ready,
    output logic                       busy,
    output logic                       err_no_tag
);

    localparam int SW     = 2 * DATA_WIDTH;
    localparam int TAG_AW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CFG  = 2'd1;
    localparam logic [1:0] S_XFER = 2'd2;

    logic [1:0]          r_state;
    logic [CH_WIDTH-1:0] r_rr_ptr;
    logic [CH_WIDTH-1:0] r_grant;
    logic [23:0]         r_cfg_lat;
    logic [23:0]         r_cfg [NUM_CH];

    logic [CH_WIDTH-1:0] r_tag_mem [TAG_DEPTH];
    logic [TAG_AW-1:0]   r_tag_wr;
    logic [TAG_AW-1:0]   r_tag_rd;
    logic [TAG_AW:0]     r_tag_cnt;
    logic                r_err;

    logic                  w_tag_empty;
    logic                  w_tag_full;
    logic [2*NUM_CH-1:0]   w_req2;
    logic                  w_found;
    logic [CH_WIDTH:0]     w_sum;
    logic [CH_WIDTH-1:0]   w_arb_ch;
    logic [CH_WIDTH-1:0]   w_next_ptr;
    logic                  w_grant_fire;
    logic                  w_cfg_fire;
    logic                  w_in_xfer;
    logic                  w_g_valid;
    logic                  w_g_last;
    logic [SW-1:0]         w_g_data;
    logic [23:0]           w_arb_cfg;
    logic                  w_xfer_done;
    logic                  w_pop;

    assign w_tag_empty = (r_tag_cnt == '0);
    // Full is judged on the registered count, so a same-cycle pop never enables a grant
    assign w_tag_full  = (r_tag_cnt == (TAG_AW+1)'(TAG_DEPTH));

    // Rotate requests so bit 0 is the channel at rr_ptr, then take the first set bit
    always_comb begin
        w_req2   = {in_valid, in_valid} >> r_rr_ptr;
        w_found  = 1'b0;
        w_sum    = '0;
        w_arb_ch = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!w_found && w_req2[k]) begin
                w_found = 1'b1;
                w_sum   = {1'b0, r_rr_ptr} + (CH_WIDTH+1)'(k);
                if (w_sum >= (CH_WIDTH+1)'(NUM_CH)) begin
                    w_sum = w_sum - (CH_WIDTH+1)'(NUM_CH);
                end
                w_arb_ch = w_sum[CH_WIDTH-1:0];
            end
        end
    end

    assign w_next_ptr   = (w_arb_ch == CH_WIDTH'(NUM_CH - 1)) ? '0 : w_arb_ch + CH_WIDTH'(1);
    assign w_grant_fire = (r_state == S_IDLE) && w_found && !w_tag_full;
    assign w_cfg_fire   = (r_state == S_CFG) && core_cfg_ready;
    assign w_in_xfer    = (r_state == S_XFER);

    // Select the granted channel's stream and the arbitration winner's config word
    always_comb begin
        w_g_valid = 1'b0;
        w_g_last  = 1'b0;
        w_g_data  = '0;
        w_arb_cfg = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (r_grant == CH_WIDTH'(c)) begin
                w_g_valid = in_valid[c];
                w_g_last  = in_last[c];
                w_g_data  = in_data[c*SW +: SW];
            end
            if (w_arb_ch == CH_WIDTH'(c)) begin
                w_arb_cfg = r_cfg[c];
            end
        end
    end

    // Zero-latency pass-through of the granted channel while in XFER
    always_comb begin
        in_ready = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            in_ready[c] = w_in_xfer && (r_grant == CH_WIDTH'(c)) && core_s_ready;
        end
    end

    assign core_s_valid   = w_in_xfer & w_g_valid;
    assign core_s_last    = w_in_xfer & w_g_last;
    assign core_s_data    = w_in_xfer ? w_g_data : '0;
    assign core_cfg_valid = (r_state == S_CFG);
    assign core_cfg_data  = (r_state == S_CFG) ? r_cfg_lat : '0;
    assign w_xfer_done    = core_s_valid & core_s_ready & core_s_last;

    // Result side: a result is only forwarded when a tag says which channel owns it
    assign o_valid      = core_m_valid & ~w_tag_empty;
    assign core_m_ready = o_ready & ~w_tag_empty;
    assign o_last       = ~rst & core_m_last;
    assign o_data       = rst ? '0 : core_m_data;
    assign o_user       = rst ? '0 : core_m_user;
    assign o_ch         = w_tag_empty ? '0 : r_tag_mem[r_tag_rd];
    assign w_pop        = o_valid & o_ready & o_last;

    assign busy       = (r_state != S_IDLE) || !w_tag_empty;
    assign err_no_tag = r_err;

    // Per-channel config registers; out-of-range channel writes are dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_cfg[c] <= '0;
            end
        end else if (cfg_wr_en) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (cfg_wr_ch == CH_WIDTH'(c)) begin
                    r_cfg[c] <= cfg_wr_data;
                end
            end
        end
    end

    // Frame FSM: grant in IDLE, hand the config word over in CFG, stream the frame in XFER
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_rr_ptr  <= '0;
            r_grant   <= '0;
            r_cfg_lat <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_fire) begin
                        r_grant   <= w_arb_ch;
                        r_cfg_lat <= w_arb_cfg;
                        r_rr_ptr  <= w_next_ptr;
                        r_state   <= S_CFG;
                    end
                end
                S_CFG: begin
                    if (w_cfg_fire) begin
                        r_state <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (w_xfer_done) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // In-order tag FIFO: pushed at grant, popped when the tagged result frame completes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag_wr  <= '0;
            r_tag_rd  <= '0;
            r_tag_cnt <= '0;
            for (int i = 0; i < TAG_DEPTH; i++) begin
                r_tag_mem[i] <= '0;
            end
        end else begin
            if (w_grant_fire) begin
                r_tag_mem[r_tag_wr] <= w_arb_ch;
                r_tag_wr            <= r_tag_wr + TAG_AW'(1);
            end
            if (w_pop) begin
                r_tag_rd <= r_tag_rd + TAG_AW'(1);
            end
            case ({w_grant_fire, w_pop})
                2'b10:   r_tag_cnt <= r_tag_cnt + (TAG_AW+1)'(1);
                2'b01:   r_tag_cnt <= r_tag_cnt - (TAG_AW+1)'(1);
                default: r_tag_cnt <= r_tag_cnt;
            endcase
        end
    end

    // Sticky flag for a core result arriving with no outstanding frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (core_m_valid && w_tag_empty) begin
            r_err <= 1'b1;
        end
    end

endmodule

// File: doc/fft_mc_frame_arb.md
Name: fft_mc_frame_arb

Overview:
- Multi-channel front/back end for the burst FFT/IFFT core.
- Arbitrates up to NUM_CH independent input frame streams into the single core input stream, round-robin at frame granularity.
- Issues a per-channel 24-bit config word to the core before each frame.
- Tags each core output frame with its originating channel through an in-order tag FIFO.

Parameters:
- NUM_CH, 4, number of input channels (2..16).
- CH_WIDTH, 2, channel index width; must be at least clog2(NUM_CH).
- DATA_WIDTH, 16, width of one real/imag component; stream words are 2*DATA_WIDTH, imag in the upper half.
- ADDR_WIDTH, 9, core index width; the user field is ADDR_WIDTH+1 bits.
- TAG_DEPTH, 4, tag FIFO depth (power of two), i.e. the maximum number of frames granted but not yet fully output.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- cfg_wr_en  in  1  write strobe for a per-channel config register
- cfg_wr_ch  in  CH_WIDTH  channel selected for the config write
- cfg_wr_data  in  24  config word (core format)
- in_valid  in  NUM_CH  per-channel input valid
- in_last  in  NUM_CH  per-channel end of frame
- in_data  in  NUM_CH*2*DATA_WIDTH  per-channel sample; channel c occupies slice c
- in_ready  out  NUM_CH  per-channel ready
- core_cfg_valid  out  1  config valid to the core
- core_cfg_data  out  24  config word to the core
- core_cfg_ready  in  1  core config ready
- core_s_valid  out  1  sample valid to the core
- core_s_last  out  1  sample last to the core
- core_s_data  out  2*DATA_WIDTH  sample data to the core
- core_s_ready  in  1  core sample ready
- core_m_valid  in  1  core result valid
- core_m_last  in  1  core result last
- core_m_data  in  2*DATA_WIDTH  core result data
- core_m_user  in  ADDR_WIDTH+1  core bin index
- core_m_ready  out  1  ready to the core
- o_valid  out  1  tagged result valid
- o_last  out  1  tagged result last
- o_data  out  2*DATA_WIDTH  tagged result data
- o_user  out  ADDR_WIDTH+1  bin index
- o_ch  out  CH_WIDTH  originating channel
- o_ready  in  1  downstream ready
- busy  out  1  high when state is not IDLE or the tag FIFO is non-empty
- err_no_tag  out  1  sticky: core_m_valid was seen while the tag FIFO was empty

Behaviour:

Reset:
- rst asserted forces state IDLE and clears the RR pointer, grant and tag FIFO.
- Config registers reset to 0.
- Every output is 0 during reset, including err_no_tag.
- Reset mid-frame abandons the frame with no recovery handshake; the core is reset alongside.

Config registers:
- cfg_wr_en writes cfg_wr_data into reg[cfg_wr_ch] on the clock edge.
- cfg_wr_ch >= NUM_CH is ignored.
- The word is captured into a grant register at grant time, so a write during CFG or XFER takes effect from that channel's next frame.

State machine (IDLE, CFG, XFER):
- IDLE: if any in_valid[c] is high and the tag FIFO is not full, grant the first requesting channel at or after rr_ptr (wrapping modulo NUM_CH). In the same edge:
  - latch grant and cfg,
  - push grant into the tag FIFO,
  - rr_ptr <= grant+1 mod NUM_CH,
  - go to CFG.
- IDLE with the tag FIFO full: no grant; all in_ready stay 0.
- CFG: core_cfg_valid=1 and core_cfg_data=latched cfg, held stable until core_cfg_ready. On core_cfg_valid&core_cfg_ready, go to XFER on the next cycle.
- XFER (combinational pass-through, zero latency):
  - core_s_valid = in_valid[grant], core_s_data = in_data[grant], core_s_last = in_last[grant].
  - in_ready[grant] = core_s_ready; all other in_ready = 0.
  - On core_s_valid&core_s_ready&core_s_last, go to IDLE.
- Minimum gap between frames is 2 cycles: the IDLE grant cycle plus at least one CFG cycle.

Output tagging:
- o_valid = core_m_valid & !tag_empty.
- core_m_ready = o_ready & !tag_empty.
- o_data, o_user and o_last pass through from the core; o_ch = tag FIFO head.
- The tag FIFO pops on o_valid&o_ready&o_last.
- Push and pop in the same cycle are both honoured and the count is unchanged. Full is evaluated before the same-cycle pop, so a grant is not permitted on the cycle a pop frees a slot.
- core_m_valid while tag_empty sets err_no_tag (sticky until rst). core_m_ready is held 0 in that condition.

Test Plan:
- Single channel: cfg reg[0]=0x000400, ch0 sends an 8-word frame -> one core_cfg transfer with 0x000400, 8 core_s beats with last on beat 8; the core result frame appears with o_ch=0.
- NUM_CH=4, all channels valid continuously -> grant order 0,1,2,3,0; each frame is preceded by its own cfg word; only the granted channel's in_ready is ever high.
- core_cfg_ready held low for 5 cycles -> core_cfg_valid and core_cfg_data stay stable, no in_ready asserts, XFER is entered the cycle after the handshake.
- TAG_DEPTH=4 with core_m_ready blocked by o_ready=0 -> after 4 granted frames the block stays in IDLE with in_ready=0; one completed output frame frees a slot and the next grant follows no earlier than the cycle after the pop.
- Core result without an outstanding grant (forced core_m_valid=1) -> err_no_tag=1 and stays 1, o_valid=0, core_m_ready=0.
- rst pulsed mid-XFER on channel 2 -> all outputs 0, tag FIFO empty, rr_ptr=0; the next request from ch1 is granted first.
